wb_stage: RTL and testbench

- Writeback stage between the MEM stage and the 32-entry general-purpose register file.
- Accepts completed instructions over a valid/ready handshake and buffers them in a 2-entry queue.
- Aligns and sign/zero-extends load data, then drives the register-file write port (waddr/wdata/we).
- Emits a commit strobe and PC, and maintains a 64-bit retired-instruction counter.

---
 rtl/wb_stage_pkg.sv | 21 ++
 rtl/wb_load_fmt.sv | 38 +++
 rtl/wb_stage.sv | 111 +++++++++++
 tb/tb_wb_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared encodings for the writeback stage: load funct3 values,
// register-file write-enable levels and the all-zero data word.
package wb_stage_pkg;

  typedef enum logic [2:0] {
    LT_LB   = 3'b000,
    LT_LH   = 3'b001,
    LT_LW   = 3'b010,
    LT_LD   = 3'b011,
    LT_LBU  = 3'b100,
    LT_LHU  = 3'b101,
    LT_LWU  = 3'b110,
    LT_RSVD = 3'b111
  } load_type_e;

  localparam logic WE_ON  = 1'b1;
  localparam logic WE_OFF = 1'b0;

  localparam logic [63:0] ZERO_WORD = 64'h0;

endpackage

// File: rtl/wb_load_fmt.sv
// Combinational load formatter: byte-lane shift followed by sign/zero
// extension, or a straight pass-through of the ALU result for non-loads.
module wb_load_fmt
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            is_load,
  input  logic [2:0]      load_type,
  input  logic [2:0]      addr_low,
  input  logic [XLEN-1:0] load_data,
  input  logic [XLEN-1:0] result,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    // Misaligned accesses simply see zeros shifted in from the top.
    shifted = load_data >> {addr_low, 3'b000};
    value   = XLEN'(ZERO_WORD);
    if (!is_load) begin
      value = result;
    end else begin
      case (load_type_e'(load_type))
        LT_LB:   value = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
        LT_LH:   value = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        LT_LW:   value = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
        LT_LD:   value = shifted;
        LT_LBU:  value = {{(XLEN-8){1'b0}}, shifted[7:0]};
        LT_LHU:  value = {{(XLEN-16){1'b0}}, shifted[15:0]};
        LT_LWU:  value = {{(XLEN-32){1'b0}}, shifted[31:0]};
        default: value = XLEN'(ZERO_WORD);
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: 2-entry FIFO of formatted results feeding the register
// file write port, with commit strobe and 64-bit retired-instruction count.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [XLEN-1:0]      mem_pc,
  input  logic [REGADDR_W-1:0] mem_rd,
  input  logic                 mem_rd_we,
  input  logic [XLEN-1:0]      mem_result,
  input  logic                 mem_is_load,
  input  logic [2:0]           mem_load_type,
  input  logic [XLEN-1:0]      mem_load_data,
  input  logic [2:0]           mem_addr_low,
  input  logic                 flush,
  input  logic                 wb_stall,
  output logic [REGADDR_W-1:0] waddr,
  output logic [XLEN-1:0]      wdata,
  output logic                 we,
  output logic                 commit_valid,
  output logic [XLEN-1:0]      commit_pc,
  output logic [63:0]          instret
);

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [REGADDR_W-1:0] rd;
    logic                 rd_we;
    logic [XLEN-1:0]      value;
  } entry_t;

  entry_t          slot0;
  entry_t          slot1;
  entry_t          incoming;
  logic [1:0]      count;
  logic [63:0]     instret_q;
  logic [XLEN-1:0] fmt_value;
  logic            push;
  logic            pop;

  wb_load_fmt #(.XLEN(XLEN)) u_fmt (
    .is_load   (mem_is_load),
    .load_type (mem_load_type),
    .addr_low  (mem_addr_low),
    .load_data (mem_load_data),
    .result    (mem_result),
    .value     (fmt_value)
  );

  assign incoming = '{pc: mem_pc, rd: mem_rd, rd_we: mem_rd_we, value: fmt_value};

  // No bypass: a full queue refuses input even in a cycle that pops.
  assign mem_ready = (count < 2'd2) && !flush;
  assign push      = mem_valid && mem_ready;
  assign pop       = (count != 2'd0) && !wb_stall && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= 64'd0;
    end else if (pop) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  // ---- queue storage (data only; validity is carried by count) ----
  always_ff @(posedge clk) begin
    if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
      slot0 <= incoming;
    end else if (pop) begin
      slot0 <= slot1;
    end
    if (push && (count == 2'd1) && !pop) begin
      slot1 <= incoming;
    end
  end

  // ---- writeback / commit outputs, live only in a pop cycle ----
  always_comb begin
    waddr        = '0;
    wdata        = '0;
    we           = WE_OFF;
    commit_valid = 1'b0;
    commit_pc    = '0;
    if (pop) begin
      waddr        = slot0.rd;
      wdata        = slot0.value;
      we           = (slot0.rd_we == WE_ON) && (slot0.rd != '0);
      commit_valid = 1'b1;
      commit_pc    = slot0.pc;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load formatting, handshake back-pressure,
// flush, instret wrap and asynchronous reset.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic [63:0] mem_pc;
  logic [4:0]  mem_rd;
  logic        mem_rd_we;
  logic [63:0] mem_result;
  logic        mem_is_load;
  logic [2:0]  mem_load_type;
  logic [63:0] mem_load_data;
  logic [2:0]  mem_addr_low;
  logic        flush;
  logic        wb_stall;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic        we;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [63:0] instret;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_instret = 64'd0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(64), .REGADDR_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_pc        (mem_pc),
    .mem_rd        (mem_rd),
    .mem_rd_we     (mem_rd_we),
    .mem_result    (mem_result),
    .mem_is_load   (mem_is_load),
    .mem_load_type (mem_load_type),
    .mem_load_data (mem_load_data),
    .mem_addr_low  (mem_addr_low),
    .flush         (flush),
    .wb_stall      (wb_stall),
    .waddr         (waddr),
    .wdata         (wdata),
    .we            (we),
    .commit_valid  (commit_valid),
    .commit_pc     (commit_pc),
    .instret       (instret)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid     = 1'b0;
    mem_pc        = 64'd0;
    mem_rd        = 5'd0;
    mem_rd_we     = 1'b0;
    mem_result    = 64'd0;
    mem_is_load   = 1'b0;
    mem_load_type = 3'd0;
    mem_load_data = 64'd0;
    mem_addr_low  = 3'd0;
  endtask

  task automatic drive(input logic ld, input logic [2:0] lt, input logic [63:0] data,
                       input logic [2:0] al, input logic [63:0] res, input logic [4:0] rd,
                       input logic rdwe, input logic [63:0] pc);
    mem_valid     = 1'b1;
    mem_is_load   = ld;
    mem_load_type = lt;
    mem_load_data = data;
    mem_addr_low  = al;
    mem_result    = res;
    mem_rd        = rd;
    mem_rd_we     = rdwe;
    mem_pc        = pc;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; wb_stall = 1'b0; idle();
    step(); step();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", we); end
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL reset_cv got=%0b want=0", commit_valid); end
    total++; if (waddr !== 5'd0 || wdata !== 64'd0 || commit_pc !== 64'd0) begin
      bad++; $display("FAIL reset_data got waddr=%0d wdata=%h pc=%h want zeros", waddr, wdata, commit_pc); end
    total++; if (instret !== 64'd0) begin bad++; $display("FAIL reset_instret got=%0d want=0", instret); end
    rst = 1'b1;
    step();
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", mem_ready); end
  endtask

  task automatic test_lb();
    drive(1'b1, 3'b000, 64'h0000_0000_0000_8000, 3'd1, 64'd0, 5'd5, 1'b1, 64'h1000);
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL lb_ready got=%0b want=1", mem_ready); end
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL lb_early got=%0b want=0", commit_valid); end
    step(); idle(); #1;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL lb_we got=%0b want=1", we); end
    total++; if (waddr !== 5'd5) begin bad++; $display("FAIL lb_waddr got=%0d want=5", waddr); end
    total++; if (wdata !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++; $display("FAIL lb_wdata got=%h want=ffffffffffffff80", wdata); end
    total++; if (commit_valid !== 1'b1 || commit_pc !== 64'h1000) begin
      bad++; $display("FAIL lb_commit got cv=%0b pc=%h want cv=1 pc=1000", commit_valid, commit_pc); end
    exp_instret = 64'd1;
    step();
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL lb_instret got=%0d want=%0d", instret, exp_instret); end
    total++; if (we !== 1'b0 || commit_valid !== 1'b0) begin bad++; $display("FAIL lb_after got we=%0b cv=%0b want 0", we, commit_valid); end
  endtask

  task automatic test_load_fmt();
    logic        ld_v [11];
    logic [2:0]  lt_v [11];
    logic [63:0] dat_v [11];
    logic [2:0]  al_v [11];
    logic [63:0] exp_v [11];
    ld_v[0]  = 1; lt_v[0]  = 3'b110; dat_v[0]  = 64'hDEAD_BEEF_1234_5678; al_v[0]  = 4; exp_v[0]  = 64'h0000_0000_DEAD_BEEF;
    ld_v[1]  = 1; lt_v[1]  = 3'b010; dat_v[1]  = 64'hDEAD_BEEF_1234_5678; al_v[1]  = 4; exp_v[1]  = 64'hFFFF_FFFF_DEAD_BEEF;
    ld_v[2]  = 1; lt_v[2]  = 3'b011; dat_v[2]  = 64'hDEAD_BEEF_1234_5678; al_v[2]  = 0; exp_v[2]  = 64'hDEAD_BEEF_1234_5678;
    ld_v[3]  = 1; lt_v[3]  = 3'b001; dat_v[3]  = 64'hDEAD_BEEF_1234_5678; al_v[3]  = 2; exp_v[3]  = 64'h0000_0000_0000_1234;
    ld_v[4]  = 1; lt_v[4]  = 3'b101; dat_v[4]  = 64'hDEAD_BEEF_1234_5678; al_v[4]  = 6; exp_v[4]  = 64'h0000_0000_0000_DEAD;
    ld_v[5]  = 1; lt_v[5]  = 3'b001; dat_v[5]  = 64'hDEAD_BEEF_1234_5678; al_v[5]  = 6; exp_v[5]  = 64'hFFFF_FFFF_FFFF_DEAD;
    ld_v[6]  = 1; lt_v[6]  = 3'b100; dat_v[6]  = 64'hDEAD_BEEF_1234_5678; al_v[6]  = 7; exp_v[6]  = 64'h0000_0000_0000_00DE;
    ld_v[7]  = 1; lt_v[7]  = 3'b000; dat_v[7]  = 64'hDEAD_BEEF_1234_5678; al_v[7]  = 0; exp_v[7]  = 64'h0000_0000_0000_0078;
    ld_v[8]  = 1; lt_v[8]  = 3'b111; dat_v[8]  = 64'hDEAD_BEEF_1234_5678; al_v[8]  = 0; exp_v[8]  = 64'h0;
    ld_v[9]  = 1; lt_v[9]  = 3'b011; dat_v[9]  = 64'hDEAD_BEEF_1234_5678; al_v[9]  = 3; exp_v[9]  = 64'h0000_00DE_ADBE_EF12;
    ld_v[10] = 0; lt_v[10] = 3'b000; dat_v[10] = 64'hDEAD_BEEF_1234_5678; al_v[10] = 5; exp_v[10] = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 11; i++) begin
      drive(ld_v[i], lt_v[i], dat_v[i], al_v[i], 64'h0123_4567_89AB_CDEF, 5'(i + 1), 1'b1, 64'(32'h2000 + 4 * i));
      step(); idle(); #1;
      total++; if (we !== 1'b1 || waddr !== 5'(i + 1)) begin
        bad++; $display("FAIL fmt%0d_we got we=%0b waddr=%0d want we=1 waddr=%0d", i, we, waddr, i + 1); end
      total++; if (wdata !== exp_v[i]) begin bad++; $display("FAIL fmt%0d_wdata got=%h want=%h", i, wdata, exp_v[i]); end
      exp_instret = exp_instret + 64'd1;
      step();
      total++; if (instret !== exp_instret) begin bad++; $display("FAIL fmt%0d_instret got=%0d want=%0d", i, instret, exp_instret); end
    end
  endtask

  task automatic test_rd_zero();
    drive(1'b0, 3'b000, 64'd0, 3'd0, 64'h55, 5'd0, 1'b1, 64'h3000);
    step(); idle(); #1;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL rd0_we got=%0b want=0", we); end
    total++; if (commit_valid !== 1'b1 || commit_pc !== 64'h3000) begin
      bad++; $display("FAIL rd0_commit got cv=%0b pc=%h want cv=1 pc=3000", commit_valid, commit_pc); end
    exp_instret = exp_instret + 64'd1;
    step();
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL rd0_instret got=%0d want=%0d", instret, exp_instret); end
  endtask

  task automatic test_stall_backpressure();
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'b000, 64'd0, 3'd0, 64'(32'hA0 + i), 5'(10 + i), 1'b1, 64'(32'h4000 + 4 * i));
      #1;
      total++; if (mem_ready !== (i < 2)) begin bad++; $display("FAIL stall_ready%0d got=%0b want=%0b", i, mem_ready, i < 2); end
      total++; if (we !== 1'b0 || commit_valid !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d got we=%0b cv=%0b want 0", i, we, commit_valid); end
      step();
    end
    idle(); wb_stall = 1'b0; #1;
    total++; if (we !== 1'b1 || waddr !== 5'd10 || wdata !== 64'hA0) begin
      bad++; $display("FAIL stall_c0 got we=%0b waddr=%0d wdata=%h want 1/10/a0", we, waddr, wdata); end
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL stall_full_pop_ready got=%0b want=0", mem_ready); end
    step();
    total++; if (we !== 1'b1 || waddr !== 5'd11 || wdata !== 64'hA1 || commit_pc !== 64'h4004) begin
      bad++; $display("FAIL stall_c1 got we=%0b waddr=%0d wdata=%h pc=%h want 1/11/a1/4004", we, waddr, wdata, commit_pc); end
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_back got=%0b want=1", mem_ready); end
    step();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL stall_drop3 got cv=%0b want=0", commit_valid); end
    exp_instret = exp_instret + 64'd2;
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL stall_instret got=%0d want=%0d", instret, exp_instret); end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 3'b000, 64'd0, 3'd0, 64'h11, 5'd1, 1'b1, 64'h5000);
    step();
    drive(1'b0, 3'b000, 64'd0, 3'd0, 64'h22, 5'd2, 1'b1, 64'h5004);
    #1;
    total++; if (mem_ready !== 1'b1 || wdata !== 64'h11 || waddr !== 5'd1) begin
      bad++; $display("FAIL b2b_first got ready=%0b waddr=%0d wdata=%h want 1/1/11", mem_ready, waddr, wdata); end
    step(); idle(); #1;
    total++; if (we !== 1'b1 || waddr !== 5'd2 || wdata !== 64'h22) begin
      bad++; $display("FAIL b2b_second got we=%0b waddr=%0d wdata=%h want 1/2/22", we, waddr, wdata); end
    step();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got cv=%0b want=0", commit_valid); end
    exp_instret = exp_instret + 64'd2;
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL b2b_instret got=%0d want=%0d", instret, exp_instret); end
  endtask

  task automatic test_flush();
    wb_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 3'b000, 64'd0, 3'd0, 64'hF0, 5'(20 + i), 1'b1, 64'h6000);
      step();
    end
    wb_stall = 1'b0; flush = 1'b1;
    drive(1'b0, 3'b000, 64'd0, 3'd0, 64'hF2, 5'd22, 1'b1, 64'h6008);
    #1;
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b want=0", mem_ready); end
    total++; if (we !== 1'b0 || commit_valid !== 1'b0) begin
      bad++; $display("FAIL flush_cycle got we=%0b cv=%0b want 0", we, commit_valid); end
    step(); flush = 1'b0; idle(); #1;
    total++; if (we !== 1'b0 || commit_valid !== 1'b0) begin
      bad++; $display("FAIL flush_after got we=%0b cv=%0b want 0", we, commit_valid); end
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL flush_empty_ready got=%0b want=1", mem_ready); end
    step();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL flush_after2 got cv=%0b want=0", commit_valid); end
    total++; if (instret !== exp_instret) begin bad++; $display("FAIL flush_instret got=%0d want=%0d", instret, exp_instret); end
  endtask

  task automatic test_wrap();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    total++; if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL wrap_preload got=%h want=all ones", instret); end
    step();
    drive(1'b0, 3'b000, 64'd0, 3'd0, 64'h77, 5'd7, 1'b1, 64'h7000);
    step(); idle();
    step();
    total++; if (instret !== 64'd0) begin bad++; $display("FAIL wrap_instret got=%h want=0", instret); end
  endtask

  task automatic test_async_reset();
    wb_stall = 1'b1;
    drive(1'b1, 3'b011, 64'h1122_3344_5566_7788, 3'd0, 64'd0, 5'd9, 1'b1, 64'h8000);
    step(); idle();
    wb_stall = 1'b0; #1;
    total++; if (we !== 1'b1 || wdata !== 64'h1122_3344_5566_7788) begin
      bad++; $display("FAIL arst_pre got we=%0b wdata=%h want 1/1122334455667788", we, wdata); end
    rst = 1'b0; #1;
    total++; if (we !== 1'b0 || commit_valid !== 1'b0) begin
      bad++; $display("FAIL arst_ctrl got we=%0b cv=%0b want 0", we, commit_valid); end
    total++; if (waddr !== 5'd0 || wdata !== 64'd0 || commit_pc !== 64'd0 || instret !== 64'd0) begin
      bad++; $display("FAIL arst_data got waddr=%0d wdata=%h pc=%h instret=%0d want zeros", waddr, wdata, commit_pc, instret); end
    #1; rst = 1'b1;
    step();
    total++; if (commit_valid !== 1'b0 || we !== 1'b0) begin
      bad++; $display("FAIL arst_abandon got cv=%0b we=%0b want 0", commit_valid, we); end
    total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%0b want=1", mem_ready); end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_load_fmt();
    test_rd_zero();
    test_stall_backpressure();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
